// File: rtl/serial_addsub_n.sv
// Bit-serial adder/subtractor: parallel load, LSB-first through one full adder, parallel result.
// Latency: done pulses WIDTH cycles after the accepting edge; ready returns one cycle later.
// Backpressure: start is honoured only while ready=1; requests in SHIFT/DONE are dropped, not queued.
// Build option: define SERIAL_ADDSUB_OVF_EN to compile in signed-overflow detection (ovf tied 0 otherwise).
module serial_addsub_n #(
    parameter int WIDTH = 8    // operand/result width, 2..64
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    // Single full-adder cell fed by the operand LSBs and the running carry
    always_comb begin
        fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
        fa_co    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and datapath control; every output is taken from a register
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtract is A + ~B + 1: invert B and seed the carry with 1
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_SHIFT;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (last_bit) begin
                    // Counter parks at WIDTH-1 so it never wraps mid-operation
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_co;
`ifdef SERIAL_ADDSUB_OVF_EN
                    // carry_q in the MSB cycle is the carry into the MSB
                    ovf_d   = carry_q ^ fa_co;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation without a done pulse
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf   = ovf_q;
`else
    assign ovf   = 1'b0;
`endif

endmodule
